// File: rtl/pcbfpga_cfg_loader_if.sv
// Byte-stream handshake between the host bridge (master) and the configuration loader (slave).
interface pcbfpga_cfg_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/pcbfpga_cfg_loader.sv
// Framed LUT INIT loader: parses SYNC/LEN/frames/CHK, shifts frames MSB first onto the config chain.
// Optional idle watchdog enabled by defining PCBFPGA_CFG_TIMEOUT_EN.
module pcbfpga_cfg_loader #(
    parameter int unsigned K         = 4,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr_i,
    pcbfpga_cfg_loader_if.slave        in_if,
    output logic                       cfg_data_o,
    output logic                       cfg_shift_o,
    output logic                       cfg_latch_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       error_o
);

    localparam int unsigned BytesLog = K - 3;
    localparam int unsigned CntW     = 16 + BytesLog;

    localparam logic [2:0] StSync  = 3'd0;
    localparam logic [2:0] StLenH  = 3'd1;
    localparam logic [2:0] StLenL  = 3'd2;
    localparam logic [2:0] StData  = 3'd3;
    localparam logic [2:0] StShift = 3'd4;
    localparam logic [2:0] StChk   = 3'd5;
    localparam logic [2:0] StDone  = 3'd6;
    localparam logic [2:0] StErr   = 3'd7;

    if (K < 3 || TIMEOUT < 1) begin : g_bad_params
        $error("pcbfpga_cfg_loader: K must be >= 3 and TIMEOUT >= 1");
    end

    logic [2:0]      state_q, state_d;
    logic [7:0]      len_hi_q, len_hi_d;
    logic [CntW-1:0] byte_cnt_q, byte_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [7:0]      chk_q, chk_d;
    logic            latch_q, latch_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic            ready;
    logic            accept;

    assign ready  = (state_q != StShift);
    assign accept = in_if.in_valid & ready;

`ifdef PCBFPGA_CFG_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TIMEOUT + 1);
    logic [WdW-1:0] wd_q, wd_d;
    logic           wd_state;

    assign wd_state = (state_q == StLenH) || (state_q == StLenL) ||
                      (state_q == StData) || (state_q == StChk);
`endif

    always_comb begin
        state_d    = state_q;
        len_hi_d   = len_hi_q;
        byte_cnt_d = byte_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        chk_d      = chk_q;
        latch_d    = 1'b0;
        done_d     = done_q;
        error_d    = error_q;
`ifdef PCBFPGA_CFG_TIMEOUT_EN
        wd_d       = '0;
`endif
        if (clr_i) begin
            // Clear wins over any byte presented in the same cycle.
            state_d    = StSync;
            done_d     = 1'b0;
            error_d    = 1'b0;
            chk_d      = '0;
            byte_cnt_d = '0;
            bit_cnt_d  = '0;
            shreg_d    = '0;
        end else begin
            case (state_q)
                StSync: begin
                    if (accept && in_if.in_data == SYNC_BYTE) begin
                        state_d = StLenH;
                        chk_d   = '0;
                    end
                end
                StLenH: begin
                    if (accept) begin
                        len_hi_d = in_if.in_data;
                        chk_d    = chk_q ^ in_if.in_data;
                        state_d  = StLenL;
                    end
                end
                StLenL: begin
                    if (accept) begin
                        chk_d      = chk_q ^ in_if.in_data;
                        // Frame count scaled to a byte count; the extra bits absorb LEN=FFFF.
                        byte_cnt_d = CntW'({len_hi_q, in_if.in_data}) << BytesLog;
                        state_d    = ({len_hi_q, in_if.in_data} == 16'd0) ? StChk : StData;
                    end
                end
                StData: begin
                    if (accept) begin
                        shreg_d   = in_if.in_data;
                        chk_d     = chk_q ^ in_if.in_data;
                        bit_cnt_d = '0;
                        state_d   = StShift;
                    end
                end
                StShift: begin
                    shreg_d   = {shreg_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        byte_cnt_d = byte_cnt_q - CntW'(1);
                        state_d    = (byte_cnt_q == CntW'(1)) ? StChk : StData;
                    end
                end
                StChk: begin
                    if (accept) begin
                        if (in_if.in_data == chk_q) begin
                            latch_d = 1'b1;
                            done_d  = 1'b1;
                            state_d = StDone;
                        end else begin
                            error_d = 1'b1;
                            state_d = StErr;
                        end
                    end
                end
                default: ;
            endcase
`ifdef PCBFPGA_CFG_TIMEOUT_EN
            // Stalls are counted only while the loader is waiting on the host.
            if (wd_state && !in_if.in_valid) begin
                if (wd_q == WdW'(TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    state_d = StErr;
                end else begin
                    wd_d = wd_q + WdW'(1);
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StSync;
            len_hi_q   <= '0;
            byte_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            chk_q      <= '0;
            latch_q    <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_hi_q   <= len_hi_d;
            byte_cnt_q <= byte_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            chk_q      <= chk_d;
            latch_q    <= latch_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

`ifdef PCBFPGA_CFG_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`endif

    assign in_if.in_ready = ready;
    assign cfg_shift_o    = (state_q == StShift);
    assign cfg_data_o     = cfg_shift_o & shreg_q[7];
    assign cfg_latch_o    = latch_q;
    assign busy_o         = (state_q != StSync) && (state_q != StDone) && (state_q != StErr);
    assign done_o         = done_q;
    assign error_o        = error_q;

endmodule

// File: tb/tb_pcbfpga_cfg_loader.sv
// Bench for pcbfpga_cfg_loader: directed plan items plus random framed streams vs a stream-level model.
module tb_pcbfpga_cfg_loader;

    localparam int unsigned K    = 4;
    localparam int unsigned BPF  = (1 << K) / 8;
    localparam int unsigned TO   = 16;
    localparam logic [7:0]  SYNC = 8'hA5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    logic cfg_data, cfg_shift, cfg_latch, busy, done, error;

    always #5 clk = ~clk;

    pcbfpga_cfg_loader_if bus ();

    pcbfpga_cfg_loader #(
        .K         (K),
        .SYNC_BYTE (SYNC),
        .TIMEOUT   (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (clr),
        .in_if       (bus),
        .cfg_data_o  (cfg_data),
        .cfg_shift_o (cfg_shift),
        .cfg_latch_o (cfg_latch),
        .busy_o      (busy),
        .done_o      (done),
        .error_o     (error)
    );

    int n_pass = 0;
    int n_total = 0;

    // Chain monitor, sampled on the falling edge.
    int cyc = 0;
    bit got_bits[$];
    int latch_cnt = 0;
    int latch_cyc = -1;
    int idle_data_bad = 0;
    int ready_in_shift = 0;

    always @(negedge clk) begin
        cyc++;
        if (cfg_shift) got_bits.push_back(cfg_data);
        else if (cfg_data !== 1'b0) idle_data_bad++;
        if (cfg_shift && bus.in_ready) ready_in_shift++;
        if (cfg_latch) begin
            latch_cnt++;
            latch_cyc = cyc;
        end
    end

    logic [7:0] stream[$];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] b, output int acc);
        int n;
        n = 0;
        @(negedge clk); #1;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 40) check("ready_wait", 256'(n), 256'd0);
        acc = cyc;
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clr_pulse();
        @(negedge clk); #1;
        bus.in_valid = 1'b0;
        clr = 1'b1;
        @(negedge clk); #1;
        clr = 1'b0;
    endtask

    // Stream-level reference: skip to SYNC, read LEN, concatenate frames, XOR for the checksum.
    task automatic model(output logic [255:0] bits, output int nbits, output bit ok,
                         output int dstart);
        int i;
        int nb;
        logic [7:0] x;
        i = 0;
        while (i < stream.size() && stream[i] != SYNC) i++;
        nb     = int'({stream[i+1], stream[i+2]}) * BPF;
        x      = stream[i+1] ^ stream[i+2];
        bits   = '0;
        nbits  = nb * 8;
        dstart = i + 3;
        for (int j = 0; j < nb; j++) begin
            bits = {bits[247:0], stream[i+3+j]};
            x    = x ^ stream[i+3+j];
        end
        ok = (stream[i+3+nb] == x);
    endtask

    task automatic run_stream(input string tag, input bit gaps, output logic [255:0] obs);
        int base_bits, base_latch, exp_n, dstart, obs_n, a;
        logic [255:0] exp_bits;
        bit exp_ok;
        int accs[$];
        bit gapped[$];
        base_bits  = got_bits.size();
        base_latch = latch_cnt;
        model(exp_bits, exp_n, exp_ok, dstart);
        for (int i = 0; i < stream.size(); i++) begin
            bit g;
            g = gaps && ($urandom_range(0, 3) == 0);
            if (g) idle($urandom_range(1, 3));
            send(stream[i], a);
            accs.push_back(a);
            gapped.push_back(g);
        end
        idle(4);
        obs_n = got_bits.size() - base_bits;
        obs   = '0;
        for (int k = base_bits; k < got_bits.size(); k++) obs = {obs[254:0], got_bits[k]};
        check({tag, " nbits"}, 256'(obs_n), 256'(exp_n));
        check({tag, " bits"}, obs, exp_bits);
        check({tag, " latches"}, 256'(latch_cnt - base_latch), 256'(exp_ok ? 1 : 0));
        if (exp_ok) check({tag, " latch_cyc"}, 256'(latch_cyc), 256'(accs[accs.size()-1] + 1));
        check({tag, " done"}, 256'(done), 256'(exp_ok));
        check({tag, " error"}, 256'(error), 256'(!exp_ok));
        check({tag, " busy"}, 256'(busy), 256'd0);
        for (int j = dstart + 1; j < dstart + exp_n / 8; j++) begin
            if (!gapped[j]) check({tag, " spacing"}, 256'(accs[j] - accs[j-1]), 256'd9);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic [255:0] obs;
        int a, lc;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst ready", 256'(bus.in_ready), 256'd1);
        check("rst shift", 256'(cfg_shift), 256'd0);
        check("rst data", 256'(cfg_data), 256'd0);
        check("rst latch", 256'(cfg_latch), 256'd0);
        check("rst busy", 256'(busy), 256'd0);
        check("rst done", 256'(done), 256'd0);
        check("rst error", 256'(error), 256'd0);
        #1 rst_n = 1'b1;

        // Good single-frame load with IN_VALID held across the whole stream.
        stream = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
        run_stream("good", 1'b0, obs);
        check("good pattern", obs, 256'h1234);

        clr_pulse();
        stream = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h28};
        run_stream("badchk", 1'b0, obs);
        clr_pulse();
        check("clr done", 256'(done), 256'd0);
        check("clr error", 256'(error), 256'd0);
        check("clr busy", 256'(busy), 256'd0);

        stream = '{8'h00, 8'h3C, 8'hA5, 8'h00, 8'h00, 8'h00};
        run_stream("zero_len", 1'b0, obs);
        clr_pulse();

        // Reset during the 4th shift cycle of the first data byte.
        lc = latch_cnt;
        send(8'hA5, a); send(8'h00, a); send(8'h01, a); send(8'h12, a);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst shift", 256'(cfg_shift), 256'd0);
        check("midrst ready", 256'(bus.in_ready), 256'd1);
        check("midrst busy", 256'(busy), 256'd0);
        bus.in_valid = 1'b0;
        @(negedge clk); #1 rst_n = 1'b1;
        check("midrst no latch", 256'(latch_cnt - lc), 256'd0);
        stream = '{8'hA5, 8'h00, 8'h01, 8'hAB, 8'hCD, 8'h67};
        run_stream("after_rst", 1'b0, obs);
        clr_pulse();

        // Clear while shifting stops the chain on the next cycle.
        send(8'hA5, a); send(8'h00, a); send(8'h01, a); send(8'h5E, a);
        @(negedge clk); #1;
        bus.in_valid = 1'b0;
        clr = 1'b1;
        @(negedge clk); #1;
        clr = 1'b0;
        check("clr_shift shift", 256'(cfg_shift), 256'd0);
        check("clr_shift busy", 256'(busy), 256'd0);

        for (int r = 0; r < 20; r++) begin
            int len, g;
            logic [7:0] x, b;
            stream.delete();
            g = $urandom_range(0, 2);
            for (int i = 0; i < g; i++) begin
                b = 8'($urandom);
                if (b == SYNC) b = 8'h5A;
                stream.push_back(b);
            end
            len = $urandom_range(0, 4);
            stream.push_back(SYNC);
            stream.push_back(8'h00);
            stream.push_back(8'(len));
            x = 8'(len);
            for (int i = 0; i < len * BPF; i++) begin
                b = 8'($urandom);
                stream.push_back(b);
                x = x ^ b;
            end
            if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
            stream.push_back(x);
            run_stream($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), obs);
            clr_pulse();
        end

        check("idle cfg_data", 256'(idle_data_bad), 256'd0);
        check("ready during shift", 256'(ready_in_shift), 256'd0);

        // Stall after LEN_HI.
        send(8'hA5, a); send(8'h00, a);
        idle(TO + 4);
`ifdef PCBFPGA_CFG_TIMEOUT_EN
        check("stall error", 256'(error), 256'd1);
        check("stall busy", 256'(busy), 256'd0);
`else
        check("stall error", 256'(error), 256'd0);
        check("stall busy", 256'(busy), 256'd1);
`endif
        clr_pulse();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pcbfpga_cfg_loader.md
Name: pcbfpga_cfg_loader

Overview:
- Configuration loader for the PCB FPGA fabric.
- Accepts a framed byte stream from the host bridge over a valid/ready handshake, checks it, and serializes each LUT INIT frame onto the fabric configuration shift chain.
- Commits the loaded chain with a one-cycle latch pulse only if the checksum matches.
- It is the writer side of the LUT INIT contents: the fabric LUTs consume what this block shifts in.

Parameters:
- K, 4: LUT input count; frame = 2**K INIT bits; legal K >= 3, so 2**K is a multiple of 8.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT, 1024: idle-cycle limit; used only with the optional feature.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  asynchronous, active-low reset.
- CLR  in  1  synchronous clear: return to S_SYNC, clear DONE/ERROR.
- IN_DATA  in  8  stream byte.
- IN_VALID  in  1  IN_DATA valid.
- IN_READY  out  1  loader accepts a byte this cycle.
- CFG_DATA  out  1  chain serial data.
- CFG_SHIFT  out  1  chain shift enable; CFG_DATA is valid when high.
- CFG_LATCH  out  1  one-cycle commit pulse.
- BUSY  out  1  high in every state except S_SYNC, S_DONE and S_ERR.
- DONE  out  1  sticky: load succeeded.
- ERROR  out  1  sticky: load failed.

Behaviour:
- Reset (RST=0, async): state S_SYNC; all outputs 0 except IN_READY=1; checksum, counters and shift register cleared.
- Byte accept: a byte is taken when IN_VALID & IN_READY on a rising edge. IN_DATA is ignored otherwise.
- Stream format: SYNC_BYTE, LEN_HI, LEN_LO, LEN frames of 2**K/8 bytes each, then CHK.
  - LEN is a 16-bit frame count.
  - CHK = XOR of every byte after SYNC_BYTE, excluding CHK itself.
- S_SYNC: IN_READY=1. A byte != SYNC_BYTE is discarded and the state holds. SYNC_BYTE goes to S_LENH with checksum cleared.
- S_LENH, then S_LENL:
  - IN_READY=1; each byte is captured and XORed into the checksum.
  - From S_LENL: LEN==0 goes to S_CHK, else S_DATA.
- S_DATA: IN_READY=1. An accepted byte is loaded into the shift register, XORed into the checksum, and the state moves to S_SHIFT.
- S_SHIFT:
  - IN_READY=0; CFG_SHIFT=1 for exactly 8 consecutive cycles, CFG_DATA MSB first.
  - First shift cycle is the cycle after acceptance.
  - Byte counter decrements after the 8th bit. Remaining bytes go back to S_DATA; all LEN*(2**K/8) bytes shifted goes to S_CHK.
  - Byte-to-byte throughput: 9 cycles minimum.
- S_CHK: IN_READY=1, CFG_SHIFT=0.
  - Accepted CHK == checksum: CFG_LATCH=1 on the next cycle for exactly 1 cycle, DONE=1, go to S_DONE.
  - Mismatch: ERROR=1, no CFG_LATCH, go to S_ERR.
- S_DONE / S_ERR:
  - IN_READY=1; bytes are consumed and dropped; flags held.
  - Only CLR or RST leaves them; CLR goes to S_SYNC with DONE=ERROR=0.
- Simultaneous events: CLR has priority over any byte accepted in the same cycle. CLR mid-S_SHIFT stops CFG_SHIFT on the next cycle; chain contents are then undefined and no latch is issued.
- Reset mid-operation: immediate return to the reset state; no CFG_LATCH.
- Width rules:
  - Byte counter is 16 + log2(2**K/8) bits, so LEN=16'hFFFF does not overflow.
  - Checksum is 8-bit XOR.
- CFG_DATA is 0 whenever CFG_SHIFT=0.

Optional Feature:
- Macro: PCBFPGA_CFG_TIMEOUT_EN.
- Defined:
  - A watchdog counts consecutive cycles in S_LENH, S_LENL, S_DATA or S_CHK with IN_VALID=0.
  - Reaching TIMEOUT sets ERROR=1 and enters S_ERR.
  - Counter clears on any accepted byte and on every state entry.
- Undefined: no watchdog; the loader waits indefinitely; TIMEOUT is unused.

Test Plan:
- Reset then stream A5 00 01 12 34 27 (K=4) -> 16 CFG_SHIFT pulses carrying 0001001000110100; CFG_LATCH 1 cycle after CHK; DONE=1, ERROR=0.
- Same stream with CHK=28 -> 16 shifts, no CFG_LATCH, ERROR=1, DONE=0; CLR -> both flags 0, BUSY=0.
- Stream 00 3C A5 00 00 00 -> leading 00 and 3C dropped; zero CFG_SHIFT pulses; CFG_LATCH pulse; DONE=1.
- IN_VALID held high throughout -> IN_READY low during each 8-cycle shift; accepted bytes exactly 9 cycles apart in S_DATA.
- RST asserted on the 4th shift cycle of a frame -> outputs at reset values immediately; no CFG_LATCH; a following clean stream loads correctly.
- With PCBFPGA_CFG_TIMEOUT_EN and TIMEOUT=16: send A5 00 then stall 16 cycles -> ERROR=1 in S_ERR. Without the macro, the same stall leaves BUSY=1 and no ERROR.
